calc_op_sequencer: RTL and testbench
====================================

# calc_op_sequencer

Executes one calculator operation per request from the keypad input parser and returns a registered result with status. It sits between the parser (operands A/B, op code, one-cycle enter pulse) and the display/result path. It sequences single-cycle add/sub/mul, a shared iterative divider, and repeated-multiply power. It exposes a busy flag and a one-cycle result-valid pulse.

## Interface
- WIDTH, 32: operand/result width
- clk  in  1: system clock, rising edge
- reset_n  in  1: asynchronous active-low reset
- op_a_int  in  WIDTH: operand A, unsigned
- op_b_int  in  WIDTH: operand B, unsigned
- op_code  in  3: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 POW, 5–7 invalid
- op_enter_pulse  in  1: one-cycle request strobe
- result  out  WIDTH: magnitude of last result; reset 0
- result_neg  out  1: result is negative (SUB only); reset 0
- result_valid  out  1: one-cycle completion pulse; reset 0
- err_code  out  2: 0 none, 1 div-by-zero, 2 overflow, 3 unsupported; reset 0
- busy  out  1: operation in progress; reset 0

## Operation
- States: IDLE, EXEC, DIV_RUN, POW_RUN, DONE.
- IDLE + op_enter_pulse: latch A, B, op_code → EXEC. Enter outside IDLE is dropped, not queued.
- EXEC:
  - ADD: A+B in WIDTH+1 bits; carry → err 2.
  - SUB: A≥B gives A−B, neg=0; else B−A, neg=1.
  - MUL: 2·WIDTH product; nonzero upper half → err 2.
  - DIV:
    - B=0 → err 1.
    - Otherwise pulse divider start → DIV_RUN.
  - POW, in priority order:
    - B=0 → 1.
    - A=0 → 0.
    - A=1 → 1.
    - Otherwise acc=1, cnt=B → POW_RUN.
  - Codes 5–7 → err 3.
  - All non-iterative paths → DONE.
- DIV_RUN: wait for divider done; quotient → result (remainder discarded) → DONE.
- POW_RUN, one multiply per cycle:
  - acc ← acc·A, cnt ← cnt−1.
  - Product upper half nonzero → err 2 → DONE immediately.
  - cnt reaches 0 → DONE.
- DONE: result_valid=1 for one cycle → IDLE. Outputs update on entering DONE.
- On any error, result=0 and neg=0.
- result, result_neg and err_code hold until the next completion.
- busy=1 in EXEC, DIV_RUN, POW_RUN and DONE.

## Timing
- Enter sampled in cycle 0.
- ADD/SUB/MUL/error/shortcut: result_valid in cycle 2.
- DIV: start in cycle 1, done in cycle 1+WIDTH, result_valid in cycle 2+WIDTH (34 at default).
- POW, A≥2, no overflow: result_valid in cycle 2+B. Overflow exits within WIDTH multiplies.
- busy rises in cycle 1 and falls after the result_valid cycle. Enter is accepted again the cycle after DONE.
- Reset mid-operation: FSM → IDLE, divider aborted, all outputs 0, no result_valid emitted.

## Configuration
- CALC_POW_EN defined: POW supported as above.
- Undefined:
  - POW_RUN and the power datapath are removed.
  - op_code 4 → err 3, result_valid in cycle 2.

## Structure
- Package calc_pkg holds:
  - op_code_e (OP_ADD..OP_POW)
  - err_code_e (ERR_NONE, ERR_DIV0, ERR_OVF, ERR_UNSUP)
  - seq_state_e
  - CALC_WIDTH=32
- Sub-module calc_iter_div: restoring divider.
  - Ports: clk, reset_n, start, dividend, divisor, quotient, remainder, done.
  - One quotient bit per cycle, done pulse WIDTH cycles after start.
  - Ignores start while running.

## Test plan
- 12345 ADD 678 → result 13023, neg 0, err 0, result_valid exactly in cycle 2, busy high cycles 1–2.
- 5 SUB 9 → result 4, neg 1. 99999 MUL 99999 → 9999800001, which exceeds 32 bits, so err 2, result 0.
- 99999 DIV 7 → 14285, result_valid in cycle 34. Same request with B=0 → err 1 in cycle 2.
- CALC_POW_EN defined:
  - 2 POW 10 → 1024 in cycle 12.
  - 7 POW 0 → 1.
  - 1 POW 99999 → 1 in cycle 2.
  - 99999 POW 3 → err 2.
- CALC_POW_EN undefined: op_code 4 → err 3. op_code 6 → err 3 in both builds.
- Enter pulsed during DIV_RUN → ignored, exactly one result_valid.
- reset_n low in cycle 10 of a division → outputs 0, no result_valid; next ADD completes normally.

Source files
------------

// File: rtl/calc_pkg.sv
// ============================================================================
//  Module      : calc_pkg
//  Description : Shared types and constants for the calculator op sequencer:
//                op codes, error codes, sequencer states and default width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package calc_pkg;

    localparam int CALC_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_MUL = 3'd2,
        OP_DIV = 3'd3,
        OP_POW = 3'd4
    } op_code_e;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_DIV0  = 2'd1,
        ERR_OVF   = 2'd2,
        ERR_UNSUP = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_EXEC    = 3'd1,
        S_DIV_RUN = 3'd2,
        S_POW_RUN = 3'd3,
        S_DONE    = 3'd4
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/calc_iter_div.sv
// ============================================================================
//  Module      : calc_iter_div
//  Description : Restoring unsigned divider, one quotient bit per cycle.
//                The first bit is resolved on the start edge, so done pulses
//                exactly WIDTH cycles after start. Start is ignored while a
//                division is running. WIDTH must be at least 2.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_iter_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);

    logic             r_busy;
    logic             r_done;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;

    logic             w_load;
    logic [WIDTH-1:0] w_rem_in;
    logic [WIDTH-1:0] w_quo_in;
    logic [WIDTH-1:0] w_dvs;
    logic [WIDTH:0]   w_trial;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_load = start & ~r_busy;

    // A fresh start feeds the first step straight from the inputs.
    assign w_rem_in = w_load ? '0       : r_rem;
    assign w_quo_in = w_load ? dividend : r_quo;
    assign w_dvs    = w_load ? divisor  : r_dvs;

    // One restoring step: shift the next dividend bit in, subtract if it fits.
    always_comb begin
        w_trial   = {w_rem_in, w_quo_in[WIDTH-1]};
        w_fits    = (w_trial >= {1'b0, w_dvs});
        w_rem_nxt = w_fits ? (w_trial[WIDTH-1:0] - w_dvs) : w_trial[WIDTH-1:0];
        w_quo_nxt = {w_quo_in[WIDTH-2:0], w_fits};
    end

    // Iteration state: load on start, step until the last bit, then pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_dvs  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= w_quo_nxt;
                r_dvs  <= divisor;
                r_cnt  <= CW'(WIDTH - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == CW'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign quotient  = r_quo;
    assign remainder = r_rem;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: rtl/calc_op_sequencer.sv
// ============================================================================
//  Module      : calc_op_sequencer
//  Description : Runs one calculator operation per enter pulse (add, sub,
//                mul, iterative divide, repeated-multiply power) and returns
//                a registered result with sign, error code and valid pulse.
//                Build option CALC_POW_EN enables the power operation; when
//                undefined, op code 4 reports unsupported.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH = CALC_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] op_a_int,
    input  logic [WIDTH-1:0] op_b_int,
    input  logic [2:0]       op_code,
    input  logic             op_enter_pulse,
    output logic [WIDTH-1:0] result,
    output logic             result_neg,
    output logic             result_valid,
    output logic [1:0]       err_code,
    output logic             busy
);

    seq_state_e       r_state;
    seq_state_e       w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_result;
    logic             r_neg;
    err_code_e        r_err;

    logic             w_upd;
    logic [WIDTH-1:0] w_res;
    logic             w_neg;
    err_code_e        w_err;
    logic             w_div_start;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_mul_x;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_prod_ovf;

    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;
    logic             w_div_done;

`ifdef CALC_POW_EN
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_cnt;
    logic             w_pow_init;
    logic             w_pow_step;

    // The single multiplier is shared: A*B for MUL, acc*A while powering.
    assign w_mul_x = (r_state == S_POW_RUN) ? r_acc : r_b;
`else
    assign w_mul_x = r_b;
`endif

    assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
    assign w_prod     = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, w_mul_x};
    assign w_prod_ovf = |w_prod[2*WIDTH-1:WIDTH];

    calc_iter_div #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (w_div_start),
        .dividend  (r_a),
        .divisor   (r_b),
        .quotient  (w_div_quo),
        .remainder (w_div_rem),
        .done      (w_div_done)
    );

    // The remainder is discarded, but it must always be below the divisor.
    a_div_rem_bound : assert property (
        @(posedge clk) disable iff (!reset_n) w_div_done |-> (w_div_rem < r_b));

    // Next state and the values captured into the result registers on entry to DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_upd       = 1'b0;
        w_res       = '0;
        w_neg       = 1'b0;
        w_err       = ERR_NONE;
        w_div_start = 1'b0;
`ifdef CALC_POW_EN
        w_pow_init  = 1'b0;
        w_pow_step  = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (op_enter_pulse) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_nxt = S_DONE;
                w_upd       = 1'b1;
                case (r_op)
                    OP_ADD: begin
                        if (w_sum[WIDTH]) w_err = ERR_OVF;
                        else              w_res = w_sum[WIDTH-1:0];
                    end
                    OP_SUB: begin
                        if (r_a >= r_b) begin
                            w_res = r_a - r_b;
                        end else begin
                            w_res = r_b - r_a;
                            w_neg = 1'b1;
                        end
                    end
                    OP_MUL: begin
                        if (w_prod_ovf) w_err = ERR_OVF;
                        else            w_res = w_prod[WIDTH-1:0];
                    end
                    OP_DIV: begin
                        if (r_b == '0) begin
                            w_err = ERR_DIV0;
                        end else begin
                            w_upd       = 1'b0;
                            w_div_start = 1'b1;
                            w_state_nxt = S_DIV_RUN;
                        end
                    end
`ifdef CALC_POW_EN
                    OP_POW: begin
                        if (r_b == '0) begin
                            w_res = WIDTH'(1);
                        end else if (r_a == '0) begin
                            w_res = '0;
                        end else if (r_a == WIDTH'(1)) begin
                            w_res = WIDTH'(1);
                        end else begin
                            w_upd       = 1'b0;
                            w_pow_init  = 1'b1;
                            w_state_nxt = S_POW_RUN;
                        end
                    end
`endif
                    default: begin
                        w_err = ERR_UNSUP;
                    end
                endcase
            end
            S_DIV_RUN: begin
                if (w_div_done) begin
                    w_upd       = 1'b1;
                    w_res       = w_div_quo;
                    w_state_nxt = S_DONE;
                end
            end
`ifdef CALC_POW_EN
            S_POW_RUN: begin
                w_pow_step = 1'b1;
                if (w_prod_ovf) begin
                    w_upd       = 1'b1;
                    w_err       = ERR_OVF;
                    w_state_nxt = S_DONE;
                end else if (r_cnt == WIDTH'(1)) begin
                    w_upd       = 1'b1;
                    w_res       = w_prod[WIDTH-1:0];
                    w_state_nxt = S_DONE;
                end
            end
`endif
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register, request latch and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_err    <= ERR_NONE;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == S_IDLE) && op_enter_pulse) begin
                r_a  <= op_a_int;
                r_b  <= op_b_int;
                r_op <= op_code;
            end
            if (w_upd) begin
                r_result <= w_res;
                r_neg    <= w_neg;
                r_err    <= w_err;
            end
        end
    end

`ifdef CALC_POW_EN
    // Power accumulator and remaining-multiply counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (w_pow_init) begin
            r_acc <= WIDTH'(1);
            r_cnt <= r_b;
        end else if (w_pow_step) begin
            r_acc <= w_prod[WIDTH-1:0];
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end
`endif

    assign result       = r_result;
    assign result_neg   = r_neg;
    assign err_code     = r_err;
    assign result_valid = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_calc_op_sequencer.sv
// ============================================================================
//  Module      : tb_calc_op_sequencer
//  Description : Self-checking bench for calc_op_sequencer: directed vector
//                table, randomized ops against an arithmetic reference model,
//                and hand sequences for dropped enters and mid-op reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_calc_op_sequencer;
    import calc_pkg::*;

    localparam int W = CALC_WIDTH;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] op_a_int = '0;
    logic [W-1:0] op_b_int = '0;
    logic [2:0]   op_code = '0;
    logic         op_enter_pulse = 1'b0;
    logic [W-1:0] result;
    logic         result_neg;
    logic         result_valid;
    logic [1:0]   err_code;
    logic         busy;

    int checks = 0;
    int errors = 0;

    calc_op_sequencer #(.WIDTH(W)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .op_a_int       (op_a_int),
        .op_b_int       (op_b_int),
        .op_code        (op_code),
        .op_enter_pulse (op_enter_pulse),
        .result         (result),
        .result_neg     (result_neg),
        .result_valid   (result_valid),
        .err_code       (err_code),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [31:0] res;
        logic        neg;
        logic [1:0]  err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: results straight from the arithmetic rules, 64-bit wide.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                                  output logic [31:0] r, output logic n, output logic [1:0] e,
                                  output int lat);
        longint unsigned wide;
        longint unsigned acc;
        r = '0; n = 1'b0; e = 2'd0; lat = 2;
        case (op)
            3'd0: begin
                wide = 64'(a) + 64'(b);
                if (wide > 64'hFFFF_FFFF) e = 2'd2; else r = wide[31:0];
            end
            3'd1: begin
                if (a >= b) r = a - b; else begin r = b - a; n = 1'b1; end
            end
            3'd2: begin
                wide = 64'(a) * 64'(b);
                if (wide > 64'hFFFF_FFFF) e = 2'd2; else r = wide[31:0];
            end
            3'd3: begin
                if (b == 0) e = 2'd1; else begin r = a / b; lat = 2 + W; end
            end
`ifdef CALC_POW_EN
            3'd4: begin
                if (b == 0) r = 1;
                else if (a == 0) r = 0;
                else if (a == 1) r = 1;
                else begin
                    acc = 1;
                    for (longint i = 1; i <= longint'(b); i++) begin
                        acc = acc * 64'(a);
                        if (acc > 64'hFFFF_FFFF) begin
                            e = 2'd2;
                            lat = 2 + int'(i);
                            break;
                        end
                    end
                    if (e == 2'd0) begin
                        r = acc[31:0];
                        lat = 2 + int'(b);
                    end
                end
            end
`endif
            default: e = 2'd3;
        endcase
    endfunction

    // Issue one request and check latency, outputs, busy window and hold.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] eres, input logic eneg,
                          input logic [1:0] eerr, input int elat);
        int cyc;
        bit seen;
        bit busy_ok;
        @(posedge clk); #1;
        op_a_int = a; op_b_int = b; op_code = op; op_enter_pulse = 1'b1;
        @(posedge clk); #1;
        op_enter_pulse = 1'b0;
        cyc = 1; seen = 1'b0; busy_ok = 1'b1;
        while (!seen && cyc <= 200) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (result_valid === 1'b1) seen = 1'b1;
            else begin @(posedge clk); #1; cyc++; end
        end
        chk($sformatf("%s latency", tag), 64'(seen ? cyc : 9999), 64'(elat));
        chk($sformatf("%s result", tag), 64'(result), 64'(eres));
        chk($sformatf("%s neg", tag), 64'(result_neg), 64'(eneg));
        chk($sformatf("%s err", tag), 64'(err_code), 64'(eerr));
        chk($sformatf("%s busy window", tag), 64'(busy_ok), 64'(1));
        @(posedge clk); #1;
        chk($sformatf("%s valid drop", tag), 64'({result_valid, busy}), 64'(0));
        chk($sformatf("%s hold", tag), 64'(result), 64'(eres));
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        logic [31:0] ra, rb, rr;
        logic [2:0]  rop;
        logic        rn;
        logic [1:0]  re;
        int          rl;
        int          vcount;
        int          vcyc;
        logic [31:0] vres;

        // Directed vectors with hand-derived expectations.
        vecs.push_back('{32'd12345,      32'd678,   3'd0, 32'd13023,      1'b0, 2'd0, 2});
        vecs.push_back('{32'd5,          32'd9,     3'd1, 32'd4,          1'b1, 2'd0, 2});
        vecs.push_back('{32'd7,          32'd7,     3'd1, 32'd0,          1'b0, 2'd0, 2});
        vecs.push_back('{32'd99999,      32'd99999, 3'd2, 32'd0,          1'b0, 2'd2, 2});
        vecs.push_back('{32'd65536,      32'd65535, 3'd2, 32'hFFFF_0000,  1'b0, 2'd0, 2});
        vecs.push_back('{32'd65536,      32'd65536, 3'd2, 32'd0,          1'b0, 2'd2, 2});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,     3'd0, 32'd0,          1'b0, 2'd2, 2});
        vecs.push_back('{32'hFFFF_FFFF,  32'd0,     3'd0, 32'hFFFF_FFFF,  1'b0, 2'd0, 2});
        vecs.push_back('{32'd99999,      32'd7,     3'd3, 32'd14285,      1'b0, 2'd0, 34});
        vecs.push_back('{32'd99999,      32'd0,     3'd3, 32'd0,          1'b0, 2'd1, 2});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,     3'd3, 32'hFFFF_FFFF,  1'b0, 2'd0, 34});
        vecs.push_back('{32'd3,          32'd4,     3'd6, 32'd0,          1'b0, 2'd3, 2});
`ifdef CALC_POW_EN
        vecs.push_back('{32'd2,          32'd10,    3'd4, 32'd1024,       1'b0, 2'd0, 12});
        vecs.push_back('{32'd7,          32'd0,     3'd4, 32'd1,          1'b0, 2'd0, 2});
        vecs.push_back('{32'd1,          32'd99999, 3'd4, 32'd1,          1'b0, 2'd0, 2});
        vecs.push_back('{32'd0,          32'd5,     3'd4, 32'd0,          1'b0, 2'd0, 2});
        vecs.push_back('{32'd99999,      32'd3,     3'd4, 32'd0,          1'b0, 2'd2, 4});
        vecs.push_back('{32'd2,          32'd31,    3'd4, 32'h8000_0000,  1'b0, 2'd0, 33});
        vecs.push_back('{32'd2,          32'd32,    3'd4, 32'd0,          1'b0, 2'd2, 34});
`else
        vecs.push_back('{32'd2,          32'd10,    3'd4, 32'd0,          1'b0, 2'd3, 2});
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", 64'(result), 64'(0));
        chk("reset flags", 64'({result_neg, result_valid, busy}), 64'(0));
        chk("reset err", 64'(err_code), 64'(0));
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_op($sformatf("vec%0d", i), v.a, v.b, v.op, v.res, v.neg, v.err, v.lat);
        end

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : 32'($urandom);
            rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 12)) : 32'($urandom);
            rop = 3'($urandom_range(0, 7));
            model(ra, rb, rop, rr, rn, re, rl);
            run_op($sformatf("rnd%0d op%0d", i, rop), ra, rb, rop, rr, rn, re, rl);
        end

        // Enter pulsed during a division is dropped.
        @(posedge clk); #1;
        op_a_int = 32'd99999; op_b_int = 32'd7; op_code = 3'd3; op_enter_pulse = 1'b1;
        @(posedge clk); #1;
        op_enter_pulse = 1'b0;
        vcount = 0; vcyc = 0; vres = '0;
        for (int c = 1; c <= 60; c++) begin
            if (c == 5) begin
                op_a_int = 32'd1; op_b_int = 32'd1; op_code = 3'd0; op_enter_pulse = 1'b1;
            end else begin
                op_enter_pulse = 1'b0;
            end
            if (result_valid === 1'b1) begin
                vcount++;
                if (vcount == 1) begin vcyc = c; vres = result; end
            end
            @(posedge clk); #1;
        end
        op_enter_pulse = 1'b0;
        chk("drop enter valid count", 64'(vcount), 64'(1));
        chk("drop enter latency", 64'(vcyc), 64'(34));
        chk("drop enter result", 64'(vres), 64'(14285));

        // Reset in cycle 10 of a division.
        @(posedge clk); #1;
        op_a_int = 32'd99999; op_b_int = 32'd7; op_code = 3'd3; op_enter_pulse = 1'b1;
        @(posedge clk); #1;
        op_enter_pulse = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("midreset result", 64'(result), 64'(0));
        chk("midreset flags", 64'({result_neg, result_valid, busy, err_code}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            if (result_valid === 1'b1) vcount++;
            @(posedge clk); #1;
        end
        chk("midreset no valid", 64'(vcount), 64'(0));
        run_op("post reset add", 32'd12345, 32'd678, 3'd0, 32'd13023, 1'b0, 2'd0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
